// File: rtl/rr_mux_arbiter_pkg.sv
// Shared constants and types for the round-robin mux arbiter.
// Sizes of the requester array, data path, select and beat counter.
package rr_mux_arbiter_pkg;

   localparam int NUM_REQ = 8;
   localparam int DATA_W  = 4;
   localparam int SEL_W   = 3;
   localparam int CNT_W   = 4;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   typedef struct packed {
      logic             found;
      logic [SEL_W-1:0] idx;
   } pick_t;

endpackage

// File: rtl/rr_mux_arbiter_mux.sv
// 8:1 data mux shared by all requesters.
// Purely combinational; select comes from the arbiter's registered S.
module mux
   import rr_mux_arbiter_pkg::*;
(
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   input  logic [DATA_W-1:0] C,
   input  logic [DATA_W-1:0] D,
   input  logic [DATA_W-1:0] E,
   input  logic [DATA_W-1:0] F,
   input  logic [DATA_W-1:0] G,
   input  logic [DATA_W-1:0] H,
   input  logic [SEL_W-1:0]  S,
   output logic [DATA_W-1:0] O
);

   // Route the selected requester's data to the output.
   always_comb begin
      O = A;
      unique case (S)
         3'd0: O = A;
         3'd1: O = B;
         3'd2: O = C;
         3'd3: O = D;
         3'd4: O = E;
         3'd5: O = F;
         3'd6: O = G;
         3'd7: O = H;
      endcase
   end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one 4-bit channel among eight requesters.
// Grants bursts of up to BURST_MAX beats under a valid/ready handshake.
module rr_mux_arbiter
   import rr_mux_arbiter_pkg::*;
#(
   parameter int BURST_MAX = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] REQ,
   input  logic [DATA_W-1:0]  A,
   input  logic [DATA_W-1:0]  B,
   input  logic [DATA_W-1:0]  C,
   input  logic [DATA_W-1:0]  D,
   input  logic [DATA_W-1:0]  E,
   input  logic [DATA_W-1:0]  F,
   input  logic [DATA_W-1:0]  G,
   input  logic [DATA_W-1:0]  H,
   input  logic               O_READY,
   output logic [DATA_W-1:0]  O,
   output logic               O_VALID,
   output logic [SEL_W-1:0]   S,
   output logic [NUM_REQ-1:0] GNT,
   output logic [NUM_REQ-1:0] ACK
);

   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_MAX - 1);

   state_t             state_q, state_d;
   logic [SEL_W-1:0]   s_q, s_d;
   logic [SEL_W-1:0]   last_q, last_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic  busy;
   logic  xfer;
   logic  grant_end;
   pick_t pick;

   // Scan from last+1 upward with wrap; the previous winner is checked
   // last, so it only wins again when nobody else is asking.
   function automatic pick_t rr_pick(
      input logic [NUM_REQ-1:0] req,
      input logic [SEL_W-1:0]   last
   );
      pick_t            p;
      logic [SEL_W-1:0] idx;
      p = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = last + SEL_W'(k);
         if (req[idx]) begin
            p.found = 1'b1;
            p.idx   = idx;
         end
      end
      return p;
   endfunction

   assign busy    = (state_q == BUSY);
   assign O_VALID = busy & REQ[s_q];
   assign xfer    = O_VALID & O_READY;
   assign ACK     = gnt_q & REQ & {NUM_REQ{O_READY}};
   assign S       = s_q;
   assign GNT     = gnt_q;

   // A grant ends on withdrawal or when the final beat of a burst moves.
   assign grant_end = busy &
                      (~REQ[s_q] | (xfer & (cnt_q == LAST_BEAT)));

   assign pick = rr_pick(REQ, last_q);

   // Next-state: arbitrate when idle or at grant end, else count beats.
   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      last_d  = last_q;
      gnt_d   = gnt_q;
      cnt_d   = cnt_q;
      if (!busy || grant_end) begin
         cnt_d = '0;
         if (pick.found) begin
            state_d = BUSY;
            s_d     = pick.idx;
            last_d  = pick.idx;
            gnt_d   = NUM_REQ'(1) << pick.idx;
         end else begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      end else if (xfer) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // State registers; requester 0 is first in line after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         s_q     <= '0;
         last_q  <= SEL_W'(NUM_REQ - 1);
         gnt_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         cnt_q   <= cnt_d;
      end
   end

   mux u_mux (
      .A (A),
      .B (B),
      .C (C),
      .D (D),
      .E (E),
      .F (F),
      .G (G),
      .H (H),
      .S (s_q),
      .O (O)
   );

endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Round-robin arbiter and sequencer that shares one 4-bit output channel among eight requesters. It drives the 3-bit select of an 8:1 4-bit mux and grants one requester at a time, for a burst of up to BURST_MAX beats. Beats are transferred under a valid/ready handshake with the downstream consumer. The block sits between eight 4-bit producer ports and a single downstream sink.

## Interface
Parameters:
- BURST_MAX, 4, maximum beats per grant; legal range 1..16.

Ports, listed as name, direction, width, meaning:
- clk, in, 1, single clock; all state updates on the rising edge.
- rst, in, 1, asynchronous reset, active-high. One clock; reset is asynchronous and active-high.
- REQ, in, 8, per-requester request. REQ[i] high means requester i has a beat on its data input.
- A, B, C, D, E, F, G, H, in, 4 each, data for requesters 0..7.
- O_READY, in, 1, downstream accepts a beat this cycle.
- O, out, 4, muxed data, equal to the input selected by S (combinational).
- O_VALID, out, 1, beat on O is valid.
- S, out, 3, registered select (index of the current or last grantee).
- GNT, out, 8, registered one-hot grant; all zero when idle.
- ACK, out, 8, combinational per-requester beat accept: GNT[i] & REQ[i] & O_READY. A requester advances its data on ACK.

## Operation
- States:
  - IDLE: GNT = 0.
  - BUSY: GNT one-hot, GNT[S] = 1.
- Internal state:
  - last_ptr, 3 bits: index of the last winner.
  - beat_cnt, 4 bits: beats transferred in the current grant.
- Arbitration rule:
  - Scan REQ starting at (last_ptr+1) mod 8, ascending, wrapping from 7 to 0. The first set bit wins.
  - The current holder therefore has lowest priority. It wins again only when it is the sole requester.
- Grant start:
  - IDLE with REQ != 0 moves to BUSY at the next edge.
  - At that edge: S = winner, GNT = 1<<winner, last_ptr = winner, beat_cnt = 0.
- Beat transfer:
  - O_VALID = BUSY & REQ[S].
  - A beat transfers when O_VALID & O_READY. beat_cnt increments on each transfer.
- Grant end, evaluated every BUSY cycle:
  - (a) REQ[S] = 0, requester withdrew; or
  - (b) a beat transfers while beat_cnt == BURST_MAX-1, burst exhausted.
- Re-arbitration on grant end:
  - At the same edge, re-arbitrate over the current REQ (including REQ[S] if still high).
  - Any winner: grant it directly with beat_cnt = 0. There is no idle bubble.
  - No requests: go to IDLE. S holds its value; GNT = 0.
- O_READY low stalls. The grant is held and beat_cnt is frozen. There is no timeout.
- REQ[S] dropping mid-burst ends the grant even with O_READY high. No beat transfers that cycle.
- BURST_MAX = 1: every transferred beat triggers re-arbitration.

## Timing
- Reset values: state IDLE, GNT = 0, S = 0, last_ptr = 7 (so requester 0 has top priority after reset), beat_cnt = 0, O_VALID = 0, ACK = 0. O = A, because S = 0.
- Reset asserted mid-burst: everything returns to the reset values immediately. Asynchronous.
- Arbitration latency: REQ rising in IDLE gives GNT/S at the next edge. O_VALID follows combinationally in that cycle.
- Back-to-back grants: the new grantee's first beat can transfer on the cycle immediately after the previous grant's last beat.
- Throughput: 1 beat/cycle while O_READY is high. Switching grantees costs zero cycles.
- O, O_VALID, ACK: combinational from registered S/GNT plus the REQ/data/O_READY inputs. There is no registered data path.
- Simultaneous requests arriving while BUSY are only considered at grant end. The holder is never preempted mid-burst.

## Structure
- Shared package/include:
  - NUM_REQ = 8.
  - DATA_W = 4.
  - SEL_W = 3.
  - CNT_W = 4.
  - State encodings IDLE = 1'b0, BUSY = 1'b1.
- Sub-module: the team's existing 8:1 4-bit mux `mux` (ports A..H, S, O), instantiated as the datapath and driven by registered S.
- Round-robin priority search: a combinational function or always block inside rr_mux_arbiter. No separate module.

## Test plan
- Reset then REQ = 8'h01, O_READY = 1, A = 4'h1:
  - GNT = 8'h01 and S = 0 one cycle after the request.
  - 4 beats of 4'h1 transfer, then requester 0 is re-granted, because it is the sole requester.
- REQ = 8'hFF held, O_READY = 1, BURST_MAX = 4:
  - Grants in order 0,1,...,7,0, each exactly 4 cycles long.
  - No gap cycles; O_VALID stays continuously high.
- Requester 2 granted, O_READY held low for 5 cycles:
  - GNT holds at 8'h04 and beat_cnt is frozen. ACK = 0 throughout.
  - The burst resumes and completes after O_READY rises.
- Requester 5 granted, with REQ = 8'h21 (requester 0 also requesting); REQ[5] drops after 2 beats:
  - The grant ends that edge and GNT moves to 8'h01 on the next cycle.
- Assert rst mid-burst, with requester 3 granted and beat_cnt = 2:
  - GNT = 0, S = 0, O_VALID = 0 immediately.
  - After release with REQ = 8'h88, requester 3 wins first: the scan starts from 0.
- BURST_MAX = 1, REQ = 8'h0A:
  - Grants alternate 1,3,1,3, one beat each.
